// File: rtl/trap_pkg.sv
// Shared constants and types for machine-mode trap sequencing: cause codes,
// the trap controller state encoding and mtvec mode values.
package trap_pkg;

  localparam logic [5:0] NO_EXC = 6'h1F;

  localparam logic [5:0] EXC_INSN_MISALIGN  = 6'd0;
  localparam logic [5:0] EXC_INSN_FAULT     = 6'd1;
  localparam logic [5:0] EXC_ILLEGAL        = 6'd2;
  localparam logic [5:0] EXC_BREAKPOINT     = 6'd3;
  localparam logic [5:0] EXC_LOAD_MISALIGN  = 6'd4;
  localparam logic [5:0] EXC_LOAD_FAULT     = 6'd5;
  localparam logic [5:0] EXC_STORE_MISALIGN = 6'd6;
  localparam logic [5:0] EXC_STORE_FAULT    = 6'd7;
  localparam logic [5:0] EXC_ECALL_U        = 6'd8;
  localparam logic [5:0] EXC_ECALL_S        = 6'd9;
  localparam logic [5:0] EXC_RSVD_10        = 6'd10;
  localparam logic [5:0] EXC_ECALL_M        = 6'd11;

  localparam logic [5:0] IRQ_MEI_CODE = 6'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SAVE,
    REDIRECT,
    RET
  } state_t;

endpackage

// File: rtl/trap_vector_calc.sv
// Trap target from mtvec: aligned base, plus 4*code for interrupts in vectored
// mode. Reserved mode encodings behave as direct mode.
module trap_vector_calc
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic            is_irq,
  input  logic [5:0]      code,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;

  assign base   = mtvec & {{(XLEN-2){1'b1}}, 2'b00};
  assign offset = {{(XLEN-8){1'b0}}, code, 2'b00};
  assign target = (is_irq && (mtvec[1:0] == MTVEC_VECTORED)) ? base + offset : base;

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry/return sequencer: flushes the pipeline, updates the
// trap CSRs and redirects fetch to mtvec or mepc.
module trap_controller #(
  parameter int         XLEN   = 32,
  parameter logic [5:0] NO_EXC = trap_pkg::NO_EXC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            irq_pending,
  input  logic            mie_irq_en,
  input  logic            mret,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] mtvec,
  output logic            flush,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mtval,
  output logic            mstatus_mie,
  output logic            mstatus_mpie,
  output logic            busy
);

  trap_pkg::state_t state;

  logic            exc_take;
  logic            irq_take;
  logic            evt_irq;
  logic [5:0]      evt_code;
  logic [XLEN-1:0] evt_pc;
  logic [XLEN-1:0] evt_tval;
  logic [XLEN-1:0] vec_pc;

  // Cause codes above 0x0F are not real exceptions and read as "none".
  assign exc_take = (exc_code != NO_EXC) && (exc_code <= 6'h0F);
  assign irq_take = irq_pending & mie_irq_en & mstatus_mie;

  assign busy           = (state != trap_pkg::IDLE);
  assign flush          = (state == trap_pkg::FLUSH) || (state == trap_pkg::RET);
  assign stall          = (state == trap_pkg::FLUSH) || (state == trap_pkg::SAVE) ||
                          (state == trap_pkg::REDIRECT);
  assign redirect_valid = (state == trap_pkg::REDIRECT) || (state == trap_pkg::RET);

  trap_vector_calc #(.XLEN(XLEN)) u_vector_calc (
    .mtvec  (mtvec),
    .is_irq (evt_irq),
    .code   (evt_code),
    .target (vec_pc)
  );

  // Event capture at the sampling edge: inputs are don't-care once busy.
  always_ff @(posedge clk) begin
    if (state == trap_pkg::IDLE) begin
      if (exc_take) begin
        evt_irq  <= 1'b0;
        evt_code <= exc_code;
        evt_pc   <= exc_pc;
        evt_tval <= exc_tval;
      end else if (irq_take) begin
        evt_irq  <= 1'b1;
        evt_code <= trap_pkg::IRQ_MEI_CODE;
        evt_pc   <= commit_pc;
        evt_tval <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= trap_pkg::IDLE;
      redirect_pc  <= '0;
      mcause       <= '0;
      mepc         <= '0;
      mtval        <= '0;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b1;
    end else begin
      case (state)
        trap_pkg::IDLE: begin
          if (exc_take || irq_take) begin
            state <= trap_pkg::FLUSH;
          end else if (mret) begin
            state        <= trap_pkg::RET;
            redirect_pc  <= mepc;
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
          end
        end
        trap_pkg::FLUSH: state <= trap_pkg::SAVE;
        trap_pkg::SAVE: begin
          state        <= trap_pkg::REDIRECT;
          mcause       <= {evt_irq, {(XLEN-7){1'b0}}, evt_code};
          mepc         <= evt_pc & {{(XLEN-2){1'b1}}, 2'b00};
          mtval        <= evt_tval;
          mstatus_mpie <= mstatus_mie;
          mstatus_mie  <= 1'b0;
          redirect_pc  <= vec_pc;
        end
        trap_pkg::REDIRECT: state <= trap_pkg::IDLE;
        trap_pkg::RET:      state <= trap_pkg::IDLE;
        default:            state <= trap_pkg::IDLE;
      endcase
    end
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Consumes the 6-bit prioritised exception cause produced by the exception decoder, plus a machine interrupt request and the `mret` signal.
- Sequences machine-mode trap entry and return: pipeline flush, mcause/mepc/mtval/mstatus update, PC redirect to mtvec or mepc.
- Sits between the decode/execute/memory exception sources and the fetch stage; owns the trap-related M-mode CSR state.

Parameters:
- XLEN, 32, datapath and CSR width.
- NO_EXC, 6'h1F, cause encoding meaning "no exception present".

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- exc_code  in  6  prioritised synchronous exception cause; NO_EXC = none
- exc_pc  in  XLEN  PC of the excepting instruction
- exc_tval  in  XLEN  faulting address/instruction bits for mtval
- irq_pending  in  1  machine external interrupt pending (level)
- mie_irq_en  in  1  mie.MEIE bit from the CSR file
- mret  in  1  mret instruction committing this cycle
- commit_pc  in  XLEN  PC of the next instruction to execute (interrupt return address)
- mtvec  in  XLEN  trap vector; [1:0] = mode (0 direct, 1 vectored)
- flush  out  1  kill all in-flight instructions
- stall  out  1  hold fetch/decode while the trap sequence runs
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  XLEN  redirect target
- mcause  out  XLEN  [XLEN-1] = interrupt flag, [5:0] = code
- mepc  out  XLEN  trap return address, bits [1:0] forced to 0
- mtval  out  XLEN  trap value
- mstatus_mie  out  1  global interrupt enable
- mstatus_mpie  out  1  previous interrupt enable
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values (async, immediate): state = IDLE; flush, stall, redirect_valid, busy = 0; redirect_pc, mcause, mepc, mtval = 0; mstatus_mie = 0; mstatus_mpie = 1.
- Event sampling happens only in IDLE. Priority: exception (exc_code != NO_EXC) > interrupt (irq_pending & mie_irq_en & mstatus_mie) > mret.
- An exception and an mret in the same cycle: the exception wins and the mret is dropped.
- Any other exc_code value above 6'h0F except NO_EXC is treated as NO_EXC.
- Inputs are ignored while busy = 1; no queueing.
- States: IDLE, FLUSH, SAVE, REDIRECT, RET.
- Trap entry, with the event sampled at rising edge N:
  - Cycle N+1, FLUSH: flush = 1, stall = 1. Latch cause, pc and tval into internal registers.
  - Cycle N+2, SAVE: stall = 1. Registered updates take effect at the end of this cycle:
    - mcause = {is_irq, zero pad, code}; interrupt code = 11.
    - mepc = exc_pc for an exception, commit_pc for an interrupt.
    - mtval = exc_tval for an exception, 0 for an interrupt.
    - mstatus_mpie = mstatus_mie; mstatus_mie = 0.
  - Cycle N+3, REDIRECT: redirect_valid = 1, stall = 1, then return to IDLE.
  - redirect_pc = {mtvec[XLEN-1:2], 2'b00}. In vectored mode for an interrupt only, add 4*code.
- mret, sampled at edge N:
  - Cycle N+1, RET: flush = 1, redirect_valid = 1, redirect_pc = mepc.
  - mstatus_mie = mstatus_mpie; mstatus_mpie = 1.
  - Return to IDLE.
- busy = (state != IDLE). flush, stall and redirect_valid are decoded combinationally from state.
- Back-to-back: a new event may be sampled in the IDLE cycle immediately following REDIRECT or RET.
- A reset asserted mid-sequence aborts it; partial CSR updates are not rolled back beyond the reset values.
- Vector addition wraps modulo 2^XLEN.

Decomposition:
- Shared package trap_pkg:
  - NO_EXC and the cause code constants (0–11, matching the exception decoder).
  - IRQ_MEI_CODE = 11.
  - State enum {IDLE, FLUSH, SAVE, REDIRECT, RET}.
  - MTVEC_DIRECT / MTVEC_VECTORED mode constants.
- One sub-module: trap_vector_calc, a combinational redirect target computation from mtvec, is_irq and code.

Test Plan:
- Illegal instruction: exc_code = 2, exc_pc = 0x100, exc_tval = 0xDEADBEEF, mtvec = 0x8000_0000, mstatus_mie = 1.
  → flush at N+1; at N+3 redirect_pc = 0x8000_0000; mcause = 2, mepc = 0x100, mtval = 0xDEADBEEF, mie = 0, mpie = 1.
- Vectored interrupt: irq_pending = 1, mie_irq_en = 1, mstatus_mie = 1, mtvec = 0x8000_0001, commit_pc = 0x204.
  → mcause = 0x8000_000B, mepc = 0x204, redirect_pc = 0x8000_002C.
- Simultaneous events: exc_code = 8 (ecall) with irq_pending and mret in the same cycle.
  → exception taken, mcause = 8; no mret redirect to the old mepc.
- Return: mret after the first trap.
  → one cycle later redirect_pc = 0x100, flush = 1, mie = 1 (restored from mpie), mpie = 1.
- Busy and masking:
  - exc_code = 5 asserted during FLUSH/SAVE → ignored; mcause stays 2.
  - irq_pending with mstatus_mie = 0 → no trap; busy stays 0.
- Reset mid-sequence: reset asserted in SAVE.
  → all outputs return to reset values asynchronously; state = IDLE; mpie = 1.
